// File: rtl/exu_logic_stage_if.sv
// Bundle of the execute slice's decode-side, Logic-unit-side and writeback-side signals.
// Ports: in_* (decode valid/ready + operands), logic_* (Logic unit drive/return),
//        out_* (writeback valid/ready + result), retired_cnt (completed handshakes).
interface exu_logic_stage_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    // decode side
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_pc;
    logic             in_src1_sel;
    logic             in_src2_sel;
    logic [1:0]       in_op;
    logic             in_word;
    logic [4:0]       in_rd;
    // Logic unit side
    logic [XLEN-1:0]  logic_src1;
    logic [XLEN-1:0]  logic_src2;
    logic [3:0]       logic_ctrl;
    logic [XLEN-1:0]  logic_result;
    // writeback side
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [4:0]       out_rd;
    logic             out_wen;
    logic             out_illegal;
    logic [CNT_W-1:0] retired_cnt;

    // Seen from the execute stage.
    modport master (
        input  in_valid, in_rs1, in_rs2, in_imm, in_pc,
               in_src1_sel, in_src2_sel, in_op, in_word, in_rd,
               logic_result, out_ready,
        output in_ready, logic_src1, logic_src2, logic_ctrl,
               out_valid, out_result, out_rd, out_wen, out_illegal, retired_cnt
    );

    // Seen from the surrounding decode / Logic unit / writeback.
    modport slave (
        output in_valid, in_rs1, in_rs2, in_imm, in_pc,
               in_src1_sel, in_src2_sel, in_op, in_word, in_rd,
               logic_result, out_ready,
        input  in_ready, logic_src1, logic_src2, logic_ctrl,
               out_valid, out_result, out_rd, out_wen, out_illegal, retired_cnt
    );
endinterface

// File: rtl/exu_logic_stage.sv
// Two-stage execute slice feeding the 64-bit Logic unit: operand select -> Logic -> writeback.
// Latency: 2 cycles from input accept to out_valid; 1 op/cycle when out_ready stays high.
// Backpressure: holds up to 2 ops; in_ready falls when both stages are full and out_ready is low.
// Ports: clk, rst (async, active-high) and bus (exu_logic_stage_if.master) carrying
//        the decode handshake, Logic unit drive/return and writeback handshake.
module exu_logic_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    exu_logic_stage_if.master  bus
);

    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    // stage 1: selected operands waiting on the Logic unit
    logic             s1_valid;
    logic [XLEN-1:0]  s1_src1;
    logic [XLEN-1:0]  s1_src2;
    logic [1:0]       s1_op;
    logic             s1_word;
    logic [4:0]       s1_rd;

    // stage 2: finished result waiting on writeback
    logic             s2_valid;
    logic [XLEN-1:0]  s2_result;
    logic [4:0]       s2_rd;
    logic             s2_illegal;
    logic [CNT_W-1:0] retired;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic             retire;
    logic [XLEN-1:0]  res_next;

    // in_ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        s2_free = !s2_valid || bus.out_ready;
        s1_adv  = s1_valid && s2_free;
        accept  = bus.in_valid && (!s1_valid || s1_adv);
        retire  = s2_valid && bus.out_ready;
    end

    // Post-processing of the Logic unit result before it is registered.
    always_comb begin
        res_next = bus.logic_result;
        if (s1_word) begin
            res_next = {{(XLEN-32){bus.logic_result[31]}}, bus.logic_result[31:0]};
        end
        if (s1_op == OP_ILLEGAL) begin
            res_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_src1  <= '0;
            s1_src2  <= '0;
            s1_op    <= 2'd0;
            s1_word  <= 1'b0;
            s1_rd    <= 5'd0;
        end else if (accept) begin
            // covers accept-while-advancing: new contents replace the departing op
            s1_valid <= 1'b1;
            s1_src1  <= bus.in_src1_sel ? bus.in_pc  : bus.in_rs1;
            s1_src2  <= bus.in_src2_sel ? bus.in_imm : bus.in_rs2;
            s1_op    <= bus.in_op;
            s1_word  <= bus.in_word;
            s1_rd    <= bus.in_rd;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_rd      <= 5'd0;
            s2_illegal <= 1'b0;
        end else if (s1_adv) begin
            s2_valid   <= 1'b1;
            s2_result  <= res_next;
            s2_rd      <= s1_rd;
            s2_illegal <= (s1_op == OP_ILLEGAL);
        end else if (retire) begin
            s2_valid   <= 1'b0;
        end
    end

    // Free-running wrap at all-ones; illegal ops retire like any other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 1'b1;
        end
    end

    assign bus.in_ready    = !s1_valid || s1_adv;
    assign bus.logic_src1  = s1_src1;
    assign bus.logic_src2  = s1_src2;
    // Code 3 passes through unchanged; the Logic unit resolves it to zero.
    assign bus.logic_ctrl  = s1_valid ? {2'b00, s1_op} : 4'd0;
    assign bus.out_valid   = s2_valid;
    assign bus.out_result  = s2_result;
    assign bus.out_rd      = s2_rd;
    assign bus.out_wen     = s2_valid && (s2_rd != 5'd0);
    assign bus.out_illegal = s2_illegal;
    assign bus.retired_cnt = retired;

endmodule

// File: tb/tb_exu_logic_stage.sv
// Directed bench for exu_logic_stage with a behavioural Logic unit on the return path.
module tb_exu_logic_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exu_logic_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    exu_logic_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Logic unit: 0 AND, 1 XOR, 2 OR, anything else 0.
    assign bus.logic_result =
        (bus.logic_ctrl == 4'd0) ? (bus.logic_src1 & bus.logic_src2) :
        (bus.logic_ctrl == 4'd1) ? (bus.logic_src1 ^ bus.logic_src2) :
        (bus.logic_ctrl == 4'd2) ? (bus.logic_src1 | bus.logic_src2) : '0;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] imm, input logic [63:0] pc,
                         input logic s1sel, input logic s2sel, input logic [1:0] op,
                         input logic word, input logic [4:0] rd);
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_imm      = imm;
        bus.in_pc       = pc;
        bus.in_src1_sel = s1sel;
        bus.in_src2_sel = s2sel;
        bus.in_op       = op;
        bus.in_word     = word;
        bus.in_rd       = rd;
        bus.in_valid    = 1'b1;
    endtask

    // Waits (bounded) for in_ready, then lets the accepting edge pass; in_valid stays up.
    task automatic accept_op(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, "_accept_wait"}, 64'(n < 20), 64'd1);
        tick();
    endtask

    task automatic check_out(input string tag, input logic [63:0] res, input logic [4:0] rd,
                             input logic wen, input logic ill);
        check_val({tag, "_valid"},   64'(bus.out_valid),   64'd1);
        check_val({tag, "_result"},  bus.out_result,       res);
        check_val({tag, "_rd"},      64'(bus.out_rd),      64'(rd));
        check_val({tag, "_wen"},     64'(bus.out_wen),     64'(wen));
        check_val({tag, "_illegal"}, 64'(bus.out_illegal), 64'(ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        drive(64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0);
        bus.in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // reset state
        check_val("rst_in_ready",  64'(bus.in_ready),    64'd1);
        check_val("rst_out_valid", 64'(bus.out_valid),   64'd0);
        check_val("rst_retired",   64'(bus.retired_cnt), 64'd0);
        check_val("rst_ctrl",      64'(bus.logic_ctrl),  64'd0);
        check_val("rst_result",    bus.out_result,       64'd0);
        check_val("rst_wen",       64'(bus.out_wen),     64'd0);

        // AND, register operands, exact 2-cycle latency
        bus.out_ready = 1'b1;
        drive(64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'd0, 64'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd5);
        accept_op("and");
        bus.in_valid = 1'b0;
        check_val("and_s1_ctrl",  64'(bus.logic_ctrl), 64'd0);
        check_val("and_s1_src1",  bus.logic_src1,      64'hFFFF0000FFFF0000);
        check_val("and_s1_src2",  bus.logic_src2,      64'h0F0F0F0F0F0F0F0F);
        check_val("and_latency",  64'(bus.out_valid),  64'd0);
        tick();
        check_out("and", 64'h0F0F00000F0F0000, 5'd5, 1'b1, 1'b0);
        tick();
        exp_cnt++;
        check_val("and_retired", 64'(bus.retired_cnt), 64'(exp_cnt));
        check_val("and_drained", 64'(bus.out_valid),   64'd0);

        // XOR word op from pc/imm: low word 0x7FFFFFFF has bit31 clear
        drive(64'h1234, 64'h5555, 64'hFFFFFFFFFFFFFFFF, 64'h80000000, 1'b1, 1'b1, 2'd1, 1'b1, 5'd7);
        accept_op("xorw");
        bus.in_valid = 1'b0;
        check_val("xorw_src1", bus.logic_src1,      64'h80000000);
        check_val("xorw_src2", bus.logic_src2,      64'hFFFFFFFFFFFFFFFF);
        check_val("xorw_ctrl", 64'(bus.logic_ctrl), 64'd1);
        tick();
        check_out("xorw", 64'h000000007FFFFFFF, 5'd7, 1'b1, 1'b0);
        tick();
        exp_cnt++;

        // XOR word op whose bit31 is set: sign extension fills the upper word
        drive(64'h1234, 64'h5555, 64'd0, 64'h80000000, 1'b1, 1'b1, 2'd1, 1'b1, 5'd8);
        accept_op("xorw2");
        bus.in_valid = 1'b0;
        tick();
        check_out("xorw2", 64'hFFFFFFFF80000000, 5'd8, 1'b1, 1'b0);
        tick();
        exp_cnt++;
        check_val("xorw2_retired", 64'(bus.retired_cnt), 64'(exp_cnt));

        // back-to-back with out_ready high: one result per cycle
        drive(64'hF0, 64'hFF, 64'd0, 64'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd1);
        accept_op("b2b_a");
        drive(64'hF0, 64'h0F, 64'd0, 64'd0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd2);
        check_val("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check_out("b2b_a", 64'hF0, 5'd1, 1'b1, 1'b0);
        tick();
        exp_cnt++;
        check_out("b2b_b", 64'hFF, 5'd2, 1'b1, 1'b0);
        check_val("b2b_retired1", 64'(bus.retired_cnt), 64'(exp_cnt));
        tick();
        exp_cnt++;
        check_val("b2b_retired2", 64'(bus.retired_cnt), 64'(exp_cnt));
        check_val("b2b_drained",  64'(bus.out_valid),   64'd0);

        // stall: two ORs fill both stages, a third waits
        bus.out_ready = 1'b0;
        drive(64'h00F0, 64'h0F00, 64'd0, 64'd0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd3);
        accept_op("stall_a");
        drive(64'h1, 64'h8000000000000000, 64'd0, 64'd0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd4);
        check_val("stall_second_ready", 64'(bus.in_ready), 64'd1);
        tick();
        drive(64'h10, 64'h20, 64'd0, 64'd0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            check_val("stall_in_ready", 64'(bus.in_ready),   64'd0);
            check_val("stall_valid",    64'(bus.out_valid),  64'd1);
            check_val("stall_result",   bus.out_result,      64'h0FF0);
            check_val("stall_rd",       64'(bus.out_rd),     64'd3);
            tick();
        end
        check_val("stall_retired", 64'(bus.retired_cnt), 64'(exp_cnt));
        bus.out_ready = 1'b1;
        #1;
        check_val("release_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        exp_cnt++;
        check_out("drain_b", 64'h8000000000000001, 5'd4, 1'b1, 1'b0);
        check_val("drain_b_retired", 64'(bus.retired_cnt), 64'(exp_cnt));
        tick();
        exp_cnt++;
        check_out("drain_c", 64'h30, 5'd9, 1'b1, 1'b0);
        check_val("drain_c_retired", 64'(bus.retired_cnt), 64'(exp_cnt));
        tick();
        exp_cnt++;
        check_val("drain_retired", 64'(bus.retired_cnt), 64'(exp_cnt));
        check_val("drain_empty",   64'(bus.out_valid),   64'd0);

        // illegal op to x0
        drive(64'hFFFF, 64'hFFFF, 64'd0, 64'd0, 1'b0, 1'b0, 2'd3, 1'b0, 5'd0);
        accept_op("ill");
        bus.in_valid = 1'b0;
        check_val("ill_ctrl", 64'(bus.logic_ctrl), 64'd3);
        tick();
        check_out("ill", 64'd0, 5'd0, 1'b0, 1'b1);
        tick();
        exp_cnt++;
        check_val("ill_retired", 64'(bus.retired_cnt), 64'(exp_cnt));

        // reset with both stages full and writeback stalled
        bus.out_ready = 1'b0;
        drive(64'hFF, 64'h0F, 64'd0, 64'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd1);
        accept_op("full_a");
        drive(64'hF0, 64'h0F, 64'd0, 64'd0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd2);
        tick();
        bus.in_valid = 1'b0;
        check_val("full_valid",    64'(bus.out_valid), 64'd1);
        check_val("full_in_ready", 64'(bus.in_ready),  64'd0);
        #1 rst = 1'b1;
        #1;
        check_val("mid_rst_valid",    64'(bus.out_valid),   64'd0);
        check_val("mid_rst_in_ready", 64'(bus.in_ready),    64'd1);
        check_val("mid_rst_retired",  64'(bus.retired_cnt), 64'd0);
        check_val("mid_rst_ctrl",     64'(bus.logic_ctrl),  64'd0);
        check_val("mid_rst_result",   bus.out_result,       64'd0);
        tick();
        rst = 1'b0;
        tick();
        check_val("post_rst_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        drive(64'hAA, 64'hFF, 64'd0, 64'd0, 1'b0, 1'b0, 2'd1, 1'b0, 5'd10);
        accept_op("post");
        bus.in_valid = 1'b0;
        tick();
        check_out("post", 64'h55, 5'd10, 1'b1, 1'b0);
        tick();
        check_val("post_retired", 64'(bus.retired_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
